// File: rtl/pc_adder_pkg.sv
// rtl/pc_adder_pkg.sv - shared constants, PC type and saturating-increment helper for pc_adder
package pc_adder_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 11;
  localparam int unsigned DEFAULT_INCREMENT = 1;
  localparam int WRAP_COUNT_WIDTH = 8;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] pc_addr_t;

  // Increment that sticks at all-ones instead of rolling over to zero.
  function automatic logic [WRAP_COUNT_WIDTH-1:0] sat_inc(
    input logic [WRAP_COUNT_WIDTH-1:0] value
  );
    if (&value) begin
      return value;
    end
    return value + WRAP_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pc_adder_if.sv
// rtl/pc_adder_if.sv - PC adder signal bundle; wrap signals present only with PC_ADDER_WRAP_DETECT_EN
interface pc_adder_if
  import pc_adder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);

  logic [ADDRESS_WIDTH-1:0] pc_adder_in;
  logic [ADDRESS_WIDTH-1:0] pc_adder_out;
  logic [ADDRESS_WIDTH-1:0] pc_adder_out_q;
`ifdef PC_ADDER_WRAP_DETECT_EN
  logic                        pc_wrap;
  logic [WRAP_COUNT_WIDTH-1:0] pc_wrap_count;

  modport master (
    output pc_adder_in,
    input  pc_adder_out,
    input  pc_adder_out_q,
    input  pc_wrap,
    input  pc_wrap_count
  );

  modport slave (
    input  pc_adder_in,
    output pc_adder_out,
    output pc_adder_out_q,
    output pc_wrap,
    output pc_wrap_count
  );
`else
  modport master (
    output pc_adder_in,
    input  pc_adder_out,
    input  pc_adder_out_q
  );

  modport slave (
    input  pc_adder_in,
    output pc_adder_out,
    output pc_adder_out_q
  );
`endif

endinterface

// File: rtl/pc_adder_wrap_detect.sv
// rtl/pc_adder_wrap_detect.sv - PC carry-out detection and saturating wrap counter
module pc_adder_wrap_detect
  import pc_adder_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned INCREMENT     = DEFAULT_INCREMENT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_WIDTH-1:0]    pc_in,
  output logic                        pc_wrap,
  output logic [WRAP_COUNT_WIDTH-1:0] pc_wrap_count
);

  // Largest PC that can take the step without carrying out of the top bit.
  localparam logic [63:0] PC_MAX = (64'd1 << ADDRESS_WIDTH) - 64'd1;
  localparam logic [ADDRESS_WIDTH-1:0] WRAP_THRESHOLD =
    ADDRESS_WIDTH'(PC_MAX - 64'(INCREMENT));

  // Carry out of the adder is equivalent to the input exceeding the threshold.
  always_comb begin
    pc_wrap = (pc_in > WRAP_THRESHOLD);
  end

  // Count wrap cycles, saturating; reset wins over a coincident wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_wrap_count <= '0;
    end else if (pc_wrap) begin
      pc_wrap_count <= sat_inc(pc_wrap_count);
    end
  end

endmodule

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - PC incrementer with registered copy; wrap detection under PC_ADDER_WRAP_DETECT_EN
module pc_adder
  import pc_adder_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned INCREMENT     = DEFAULT_INCREMENT
) (
  input  logic        clk,
  input  logic        reset,
  pc_adder_if.slave   bus
);

  if (ADDRESS_WIDTH < 2 || ADDRESS_WIDTH > 32) begin : g_bad_width
    $error("pc_adder: ADDRESS_WIDTH must be 2..32");
  end

  if (INCREMENT < 1 || 64'(INCREMENT) > (64'd1 << (ADDRESS_WIDTH - 1))) begin : g_bad_increment
    $error("pc_adder: INCREMENT must be 1..2^(ADDRESS_WIDTH-1)");
  end

  localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(INCREMENT);

  // Next PC: unsigned add, carry out of the top bit discarded; no clock or reset involvement.
  always_comb begin
    bus.pc_adder_out = bus.pc_adder_in + STEP;
  end

  // One-cycle registered copy of the next PC, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pc_adder_out_q <= '0;
    end else begin
      bus.pc_adder_out_q <= bus.pc_adder_out;
    end
  end

`ifdef PC_ADDER_WRAP_DETECT_EN
  pc_adder_wrap_detect #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .INCREMENT     (INCREMENT)
  ) u_wrap_detect (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (bus.pc_adder_in),
    .pc_wrap       (bus.pc_wrap),
    .pc_wrap_count (bus.pc_wrap_count)
  );
`endif

endmodule

// File: tb/tb_pc_adder.sv
// tb/tb_pc_adder.sv - directed self-checking bench for pc_adder (default and 8-bit/step-4 instances)
module tb_pc_adder;
  import pc_adder_pkg::*;

  typedef struct {
    pc_addr_t pc_in;
    pc_addr_t pc_out;
    logic     wrap;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_adder_if #(.ADDRESS_WIDTH(11)) bus_a ();
  pc_adder_if #(.ADDRESS_WIDTH(8))  bus_b ();

  pc_adder #(.ADDRESS_WIDTH(11), .INCREMENT(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pc_adder #(.ADDRESS_WIDTH(8), .INCREMENT(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t vec_a [7];
  vec_t vec_b [5];

  initial begin
    checks = 0;
    errors = 0;

    vec_a[0] = '{11'd0,    11'd1,    1'b0};
    vec_a[1] = '{11'd1,    11'd2,    1'b0};
    vec_a[2] = '{11'd2046, 11'd2047, 1'b0};
    vec_a[3] = '{11'd2047, 11'd0,    1'b1};
    vec_a[4] = '{11'd1023, 11'd1024, 1'b0};
    vec_a[5] = '{11'd1365, 11'd1366, 1'b0};
    vec_a[6] = '{11'd5,    11'd6,    1'b0};

    vec_b[0] = '{11'd254, 11'd2,   1'b1};
    vec_b[1] = '{11'd251, 11'd255, 1'b0};
    vec_b[2] = '{11'd252, 11'd0,   1'b1};
    vec_b[3] = '{11'd0,   11'd4,   1'b0};
    vec_b[4] = '{11'd100, 11'd104, 1'b0};

    // reset state; combinational output unaffected by reset
    reset = 1'b1;
    bus_a.pc_adder_in = 11'd5;
    bus_b.pc_adder_in = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_q_a", 32'(bus_a.pc_adder_out_q), 32'd0);
    check("reset_q_b", 32'(bus_b.pc_adder_out_q), 32'd0);
    check("reset_out_a", 32'(bus_a.pc_adder_out), 32'd6);
`ifdef PC_ADDER_WRAP_DETECT_EN
    check("reset_cnt_a", 32'(bus_a.pc_wrap_count), 32'd0);
`endif
    reset = 1'b0;

    // combinational vector tables
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus_a.pc_adder_in = vec_a[i].pc_in;
      #1;
      check($sformatf("vec_a%0d_out", i), 32'(bus_a.pc_adder_out), 32'(vec_a[i].pc_out));
`ifdef PC_ADDER_WRAP_DETECT_EN
      check($sformatf("vec_a%0d_wrap", i), 32'(bus_a.pc_wrap), 32'(vec_a[i].wrap));
`endif
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_b.pc_adder_in = 8'(vec_b[i].pc_in);
      #1;
      check($sformatf("vec_b%0d_out", i), 32'(bus_b.pc_adder_out), 32'(vec_b[i].pc_out));
`ifdef PC_ADDER_WRAP_DETECT_EN
      check($sformatf("vec_b%0d_wrap", i), 32'(bus_b.pc_wrap), 32'(vec_b[i].wrap));
`endif
    end

    // feedback chain at 1 ns spacing
    @(negedge clk);
    bus_a.pc_adder_in = 11'd0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("chain_%0d", i), 32'(bus_a.pc_adder_out), 32'(i));
      bus_a.pc_adder_in = bus_a.pc_adder_out;
    end

    // registered output, one-cycle latency, including wrap
    @(negedge clk);
    bus_a.pc_adder_in = 11'd10;
    bus_b.pc_adder_in = 8'd254;
    @(negedge clk);
    check("q_a_10", 32'(bus_a.pc_adder_out_q), 32'd11);
    check("q_b_254", 32'(bus_b.pc_adder_out_q), 32'd2);
    bus_a.pc_adder_in = 11'd2047;
    @(negedge clk);
    check("q_a_2047", 32'(bus_a.pc_adder_out_q), 32'd0);
    bus_a.pc_adder_in = 11'd3;
    @(negedge clk);
    check("q_a_3", 32'(bus_a.pc_adder_out_q), 32'd4);

    // one reset edge then input 5
    reset = 1'b1;
    bus_a.pc_adder_in = 11'd5;
    @(negedge clk);
    check("rst_edge_q", 32'(bus_a.pc_adder_out_q), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_q", 32'(bus_a.pc_adder_out_q), 32'd6);

    // reset mid-sequence, first edge after release registers current output
    bus_a.pc_adder_in = 11'd100;
    @(negedge clk);
    check("mid_pre_q", 32'(bus_a.pc_adder_out_q), 32'd101);
    reset = 1'b1;
    bus_a.pc_adder_in = 11'd200;
    @(negedge clk);
    check("mid_rst_q", 32'(bus_a.pc_adder_out_q), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_release_q", 32'(bus_a.pc_adder_out_q), 32'd201);

`ifdef PC_ADDER_WRAP_DETECT_EN
    // saturating wrap counter, reset priority
    reset = 1'b1;
    bus_a.pc_adder_in = 11'd2047;
    bus_b.pc_adder_in = 8'd251;
    @(negedge clk);
    check("cnt_rst_prio", 32'(bus_a.pc_wrap_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("cnt_1", 32'(bus_a.pc_wrap_count), 32'd1);
    repeat (253) @(negedge clk);
    check("cnt_254", 32'(bus_a.pc_wrap_count), 32'd254);
    @(negedge clk);
    check("cnt_255", 32'(bus_a.pc_wrap_count), 32'd255);
    repeat (45) @(negedge clk);
    check("cnt_sat", 32'(bus_a.pc_wrap_count), 32'd255);
    bus_a.pc_adder_in = 11'd2046;
    @(negedge clk);
    check("cnt_hold", 32'(bus_a.pc_wrap_count), 32'd255);
    check("cnt_b_nowrap", 32'(bus_b.pc_wrap_count), 32'd0);
    bus_a.pc_adder_in = 11'd2047;
    reset = 1'b1;
    @(negedge clk);
    check("cnt_clear", 32'(bus_a.pc_wrap_count), 32'd0);
    check("wrap_in_reset", 32'(bus_a.pc_wrap), 32'd1);
    reset = 1'b0;
    bus_a.pc_adder_in = 11'd2046;
    @(negedge clk);
    check("cnt_no_wrap", 32'(bus_a.pc_wrap_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_adder.md
PC_ADDER -- requirements
Module: pc_adder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 11, program-counter width in bits; SHALL be legal for values 2..32.
REQ-002 Parameter INCREMENT, default 1, constant step added to the PC; SHALL be legal for values 1..2^(ADDRESS_WIDTH-1).
REQ-003 clk  input  1  single clock; all registered state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_adder_in  input  ADDRESS_WIDTH  current PC value.
REQ-006 pc_adder_out  output  ADDRESS_WIDTH  next PC, combinational.
REQ-007 pc_adder_out_q  output  ADDRESS_WIDTH  pc_adder_out registered one cycle.
REQ-008 pc_wrap  output  1  combinational; high when pc_adder_in + INCREMENT exceeds 2^ADDRESS_WIDTH-1 (present only with PC_ADDER_WRAP_DETECT_EN).
REQ-009 pc_wrap_count  output  8  registered saturating count of wrap cycles (present only with PC_ADDER_WRAP_DETECT_EN).

Function
REQ-010 pc_adder_out SHALL equal (pc_adder_in + INCREMENT) mod 2^ADDRESS_WIDTH, purely combinational, zero cycles latency, independent of clk and reset.
REQ-011 pc_adder_out SHALL settle within 1 ns of a pc_adder_in change so feedback pc_adder_in <= pc_adder_out at 1 ns spacing yields 0,1,2,3,4.
REQ-012 Addition SHALL be unsigned; carry out of bit ADDRESS_WIDTH-1 SHALL be discarded from pc_adder_out (wrap-around, e.g. 2047 -> 0 at defaults).
REQ-013 pc_adder_out_q SHALL take the value of pc_adder_out at each rising clk edge when reset is low; latency exactly 1 cycle.
REQ-014 pc_wrap SHALL be asserted in the same cycle as the wrapping input, combinationally.
REQ-015 pc_wrap_count SHALL increment by 1 on each rising edge where pc_wrap is high and reset is low, and SHALL hold at 255 (no rollover).
REQ-016 An X/Z-free pc_adder_in SHALL always produce an X-free pc_adder_out even if clk and reset are unconnected.

Reset
REQ-017 On a rising edge with reset high, pc_adder_out_q SHALL become 0 and pc_wrap_count SHALL become 0.
REQ-018 Reset SHALL NOT affect pc_adder_out or pc_wrap; reset takes priority over a simultaneous wrap count increment.
REQ-019 Reset asserted mid-sequence SHALL clear registers on that edge; the first edge after reset deassertion SHALL register the current pc_adder_out.

Configuration
REQ-020 Macro PC_ADDER_WRAP_DETECT_EN: when defined, pc_wrap, pc_wrap_count and their logic SHALL be compiled in; when undefined, those ports and logic SHALL be absent and REQ-010..013 SHALL be unchanged.

Structure
REQ-021 Package pc_adder_pkg SHALL hold the default ADDRESS_WIDTH constant (11), default INCREMENT (1), WRAP_COUNT_WIDTH (8) and a pc_addr_t typedef of width ADDRESS_WIDTH default.
REQ-022 Sub-module pc_adder_wrap_detect SHALL implement the carry-out detection and saturating counter, instantiated only under PC_ADDER_WRAP_DETECT_EN.

Verification
REQ-023 pc_adder_in=0 -> pc_adder_out=1 within 1 ns; feedback chain at 1 ns steps -> 1,2,3,4,5 outputs.
REQ-024 pc_adder_in=2047 (defaults) -> pc_adder_out=0, pc_wrap=1; pc_adder_in=2046 -> 2047, pc_wrap=0.
REQ-025 reset high for one edge, then pc_adder_in=5 -> pc_adder_out_q=0 after reset edge, =6 after next edge.
REQ-026 Hold pc_adder_in=2047 for 300 edges with PC_ADDER_WRAP_DETECT_EN -> pc_wrap_count saturates at 255; assert reset -> 0.
REQ-027 INCREMENT=4, ADDRESS_WIDTH=8, pc_adder_in=254 -> pc_adder_out=2, pc_wrap=1.
REQ-028 Build without PC_ADDER_WRAP_DETECT_EN -> REQ-023 and REQ-025 pass unchanged.
